tx_wrr_sched: RTL and testbench
===============================

Name: tx_wrr_sched

Overview:
- Weighted round-robin scheduler for the per-sub-AFU Tx FIFOs that feed one CCI-P Tx channel.
- Replaces a blind modulo-N slot rotation with work-conserving selection: empty sub-AFUs are skipped, and a backlogged sub-AFU may hold the channel for a configurable burst.
- One instance per Tx channel (c0, c1, c2). Its one-hot grant drives the FIFO rdack lines, and its index drives the output mux select.

Parameters:
- N_SUBAFUS, 16, number of requesters; must be ≥2.
- WEIGHT_WIDTH, 4, width of the per-requester burst weight.
- LOGN, $clog2(N_SUBAFUS), index width (derived; not overridden).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- resetb  in  1  synchronous, active-low reset.
- req_v  in  N_SUBAFUS  bit i = requester i holds at least one entry not yet granted.
- dn_almFull  in  1  downstream channel almost-full; blocks new grants.
- cfg_wen  in  1  weight write strobe.
- cfg_idx  in  LOGN  weight register index.
- cfg_weight  in  WEIGHT_WIDTH  weight value (0 = requester masked).
- grant_v  out  1  a grant was issued this cycle.
- grant_idx  out  LOGN  index of the granted requester.
- grant_onehot  out  N_SUBAFUS  one-hot grant, drives FIFO rdack directly.
- stall  out  1  some eligible request was present but blocked by dn_almFull.

Behaviour:
- Reset, while resetb=0:
  - grant_v=0, grant_idx=0, grant_onehot=0, stall=0.
  - All weights=1, which is plain round-robin.
  - owner=N_SUBAFUS-1, so the first search starts at requester 0.
  - budget=0, state=IDLE.
  - Reset asserted mid-burst aborts the burst; no grant is issued in the cycle after reset is sampled low.
- Latency: req_v and dn_almFull sampled at edge t produce registered grant outputs valid after edge t. Exactly one cycle; no combinational path from inputs to outputs.
- Eligible(i) = req_v[i] & (weight[i]!=0).
- At most one grant per cycle. grant_onehot is either all-zero or has exactly one bit set, equal to (1<<grant_idx) when grant_v=1.
- State machine (IDLE, BURST); each cycle with dn_almFull=0:
  - BURST, Eligible(owner), budget>0:
    - Grant owner; budget-=1.
    - If budget was 1, go to IDLE after this grant.
  - Otherwise (IDLE, budget=0, or owner no longer eligible):
    - Search i = owner+1, owner+2, …, wrapping modulo N_SUBAFUS, ending with owner itself. Pick the first eligible requester.
    - If found: owner=i; grant i; budget=weight[i]-1.
    - Next state: BURST if budget>0, else IDLE.
    - If none found: no grant; owner unchanged; state IDLE.
- dn_almFull=1:
  - No grant; grant_v=0 the next cycle.
  - owner, budget and state are held, so a burst resumes with its remaining budget when dn_almFull clears.
  - stall=1 next cycle iff any Eligible(i) was true.
- Wrap-around: owner=N_SUBAFUS-1 searches from 0. Search order is computed with a LOGN-bit add that wraps naturally when N_SUBAFUS is a power of 2. Non-power-of-2 values use explicit compare-and-reset.
- Configuration writes:
  - cfg_wen=1 writes weight[cfg_idx] at the edge; the new value is visible to the next cycle's decision.
  - A write to the current owner does not change the remaining budget; the new weight applies at its next selection.
  - A write of 0 to the current owner makes it ineligible immediately: the burst ends and the search runs.
  - A write and a grant decision involving the same index in the same cycle use the old weight.
  - cfg_idx ≥ N_SUBAFUS is ignored.
- Requester contract:
  - req_v must already exclude entries granted in earlier cycles. The FIFO wrapper decrements its pending count on grant_onehot[i].
  - The scheduler never double-counts; it trusts req_v each cycle.
- Fairness bound: with all N requesters eligible, requester i waits at most the sum of the other requesters' weights in grant cycles (excluding dn_almFull cycles).

Decomposition:
- Shared package ccip_mux_pkg:
  - t_sched_state enum {IDLE, BURST}.
  - Default weight constant SCHED_DEFAULT_WEIGHT=1.
  - Helper function for wrapped index increment.
- Sub-module rr_find_next (purely combinational):
  - Inputs: eligible vector and start index.
  - Outputs: found flag and index.
  - Implemented as a rotate → priority encode → un-rotate, so it can be reused by the other channel schedulers.

Test Plan:
- Reset, all weights=1, req_v=16'hFFFF held, dn_almFull=0 → grant_idx 0,1,2,…,15,0 on consecutive cycles starting the cycle after resetb rises; grant_onehot matches every cycle.
- weight[3]=4, others 1, req_v=16'h0018 (requesters 3 and 4) → grants 3,3,3,3,4,3,3,3,3,4, repeating.
- req_v=16'h0001 only → grant 0 every cycle. Then drop to 0 → grant_v=0 the following cycle and stall=0.
- Mid-burst of requester 3 (weight 4) after 2 grants, dn_almFull=1 for 5 cycles → grant_v=0 and stall=1 for 5 cycles, then exactly 2 more grants to 3, then 4.
- Write weight[5]=0 while 5 is owner with req_v=16'h0060 (requesters 5 and 6) → the next cycle grants 6; requester 5 is never granted until weight[5] is rewritten non-zero.
- Apply resetb=0 mid-burst for 1 cycle → all outputs 0 the next cycle; after release, the search restarts from requester 0 with all weights back to 1.

Source files
------------

// File: rtl/ccip_mux_pkg.sv
// Shared types and helpers for the CCI-P Tx channel schedulers.
package ccip_mux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } t_sched_state;

  localparam int SCHED_DEFAULT_WEIGHT = 1;

  // Wrapped increment; also correct for non-power-of-2 requester counts.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tx_wrr_sched_if.sv
// Request/config/grant bundle between the Tx FIFO wrapper and tx_wrr_sched.
interface tx_wrr_sched_if #(
  parameter int N_SUBAFUS    = 16,
  parameter int WEIGHT_WIDTH = 4,
  parameter int LOGN         = $clog2(N_SUBAFUS)
);
  logic [N_SUBAFUS-1:0]    req_v;
  logic                    dn_almFull;
  logic                    cfg_wen;
  logic [LOGN-1:0]         cfg_idx;
  logic [WEIGHT_WIDTH-1:0] cfg_weight;
  logic                    grant_v;
  logic [LOGN-1:0]         grant_idx;
  logic [N_SUBAFUS-1:0]    grant_onehot;
  logic                    stall;

  modport master (
    output req_v, dn_almFull, cfg_wen, cfg_idx, cfg_weight,
    input  grant_v, grant_idx, grant_onehot, stall
  );

  modport slave (
    input  req_v, dn_almFull, cfg_wen, cfg_idx, cfg_weight,
    output grant_v, grant_idx, grant_onehot, stall
  );
endinterface

// File: rtl/rr_find_next.sv
// Combinational round-robin search: first set bit of eligible at or after start,
// wrapping. Rotate, priority-encode, then un-rotate.
module rr_find_next #(
  parameter int N    = 16,
  parameter int LOGN = $clog2(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [LOGN-1:0] start,
  output logic            found,
  output logic [LOGN-1:0] idx
);

  logic [N-1:0]    rot;
  logic [LOGN-1:0] ofs;

  always_comb begin
    int s;
    rot = '0;
    ofs = '0;
    s   = 0;
    for (int k = 0; k < N; k++) begin
      s = int'(start) + k;
      if (s >= N) s = s - N;
      rot[k] = eligible[LOGN'(s)];
    end
    found = |rot;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) ofs = LOGN'(k);
    end
    s = int'(start) + int'(ofs);
    if (s >= N) s = s - N;
    idx = LOGN'(s);
  end

endmodule

// File: rtl/tx_wrr_sched.sv
// Work-conserving weighted round-robin scheduler for one CCI-P Tx channel.
// Grant outputs are registered; one grant per cycle at most.
module tx_wrr_sched
  import ccip_mux_pkg::*;
#(
  parameter  int N_SUBAFUS    = 16,
  parameter  int WEIGHT_WIDTH = 4,
  localparam int LOGN         = $clog2(N_SUBAFUS)
) (
  input logic           clk,
  input logic           resetb,
  tx_wrr_sched_if.slave bus
);

  t_sched_state                           state_q, state_n;
  logic [LOGN-1:0]                        owner_q, owner_n;
  logic [WEIGHT_WIDTH-1:0]                budget_q, budget_n;
  logic [N_SUBAFUS-1:0][WEIGHT_WIDTH-1:0] weight_q;
  logic [N_SUBAFUS-1:0]                   eligible;
  logic [LOGN-1:0]                        start_idx, found_idx;
  logic                                   found, cfg_ok;
  logic                                   gv_n, stall_n;
  logic [LOGN-1:0]                        gidx_n;
  logic [N_SUBAFUS-1:0]                   goh_n;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_SUBAFUS; i++)
      eligible[i] = bus.req_v[i] && (weight_q[i] != '0);
  end

  assign start_idx = LOGN'(wrap_inc(int'(owner_q), N_SUBAFUS));

  rr_find_next #(.N(N_SUBAFUS), .LOGN(LOGN)) u_find (
    .eligible (eligible),
    .start    (start_idx),
    .found    (found),
    .idx      (found_idx)
  );

  if (N_SUBAFUS == (1 << LOGN)) begin : g_pow2
    assign cfg_ok = 1'b1;
  end else begin : g_npow2
    assign cfg_ok = ({1'b0, bus.cfg_idx} < (LOGN+1)'(N_SUBAFUS));
  end

  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    budget_n = budget_q;
    gv_n     = 1'b0;
    gidx_n   = '0;
    stall_n  = 1'b0;
    goh_n    = '0;
    if (bus.dn_almFull) begin
      // Hold owner/budget/state so the burst resumes where it left off.
      stall_n = |eligible;
    end else if (state_q == BURST && eligible[owner_q] && budget_q != '0) begin
      gv_n     = 1'b1;
      gidx_n   = owner_q;
      budget_n = budget_q - WEIGHT_WIDTH'(1);
      state_n  = (budget_q == WEIGHT_WIDTH'(1)) ? IDLE : BURST;
    end else if (found) begin
      gv_n     = 1'b1;
      gidx_n   = found_idx;
      owner_n  = found_idx;
      budget_n = weight_q[found_idx] - WEIGHT_WIDTH'(1);
      state_n  = (weight_q[found_idx] > WEIGHT_WIDTH'(1)) ? BURST : IDLE;
    end else begin
      state_n  = IDLE;
      budget_n = '0;
    end
    for (int i = 0; i < N_SUBAFUS; i++)
      goh_n[i] = gv_n && (gidx_n == LOGN'(i));
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q          <= IDLE;
      owner_q          <= LOGN'(N_SUBAFUS - 1);
      budget_q         <= '0;
      for (int i = 0; i < N_SUBAFUS; i++)
        weight_q[i]    <= WEIGHT_WIDTH'(SCHED_DEFAULT_WEIGHT);
      bus.grant_v      <= 1'b0;
      bus.grant_idx    <= '0;
      bus.grant_onehot <= '0;
      bus.stall        <= 1'b0;
    end else begin
      state_q          <= state_n;
      owner_q          <= owner_n;
      budget_q         <= budget_n;
      // Decision above already used the old weight for this cycle.
      if (bus.cfg_wen && cfg_ok)
        weight_q[bus.cfg_idx] <= bus.cfg_weight;
      bus.grant_v      <= gv_n;
      bus.grant_idx    <= gidx_n;
      bus.grant_onehot <= goh_n;
      bus.stall        <= stall_n;
    end
  end

endmodule

// File: tb/tb_tx_wrr_sched.sv
// Directed + randomized bench for tx_wrr_sched against a per-cycle reference model.
module tb_tx_wrr_sched;
  localparam int N  = 16;
  localparam int WW = 4;

  logic clk    = 1'b0;
  logic resetb = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int m_w[N];
  int m_owner;
  int m_left;

  tx_wrr_sched_if #(.N_SUBAFUS(N), .WEIGHT_WIDTH(WW)) bus();

  tx_wrr_sched #(.N_SUBAFUS(N), .WEIGHT_WIDTH(WW)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_w[i] = 1;
    m_owner = N - 1;
    m_left  = 0;
  endtask

  // One clock of stimulus; model predicts the registered outputs after the edge.
  task automatic step(input logic [N-1:0] rq, input bit af, input bit wen, input int ci, input int cw);
    bit el[N];
    bit ev, es, any;
    int ei, c;
    resetb         = 1'b1;
    bus.req_v      = rq;
    bus.dn_almFull = af;
    bus.cfg_wen    = wen;
    bus.cfg_idx    = 4'(ci);
    bus.cfg_weight = 4'(cw);
    ev = 0; es = 0; any = 0; ei = 0;
    for (int i = 0; i < N; i++) begin
      el[i] = rq[i] && (m_w[i] != 0);
      any   = any | el[i];
    end
    if (af) begin
      es = any;
    end else if (m_left > 0 && el[m_owner]) begin
      ev = 1; ei = m_owner; m_left--;
    end else begin
      m_left = 0;
      for (int k = 1; k <= N && !ev; k++) begin
        c = (m_owner + k) % N;
        if (el[c]) begin
          ev = 1; ei = c; m_owner = c; m_left = m_w[c] - 1;
        end
      end
    end
    if (wen && ci < N) m_w[ci] = cw;
    @(posedge clk); #1;
    bus.cfg_wen = 1'b0;
    chk("grant_v", 32'(bus.grant_v), 32'(ev));
    chk("grant_onehot", 32'(bus.grant_onehot), ev ? (32'd1 << ei) : 32'd0);
    chk("stall", 32'(bus.stall), 32'(es));
    if (ev) chk("grant_idx", 32'(bus.grant_idx), 32'(ei));
  endtask

  task automatic do_reset();
    resetb      = 1'b0;
    bus.cfg_wen = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_grant_v", 32'(bus.grant_v), 32'd0);
    chk("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst_grant_onehot", 32'(bus.grant_onehot), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
  endtask

  initial begin
    bus.req_v      = '0;
    bus.dn_almFull = 1'b0;
    bus.cfg_wen    = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_weight = '0;
    do_reset();
    do_reset();

    // Plain round-robin over all requesters from reset
    for (int i = 0; i < 17; i++) begin
      step(16'hFFFF, 0, 0, 0, 0);
      chk("rr_seq", 32'(bus.grant_idx), 32'(i % 16));
    end

    // weight[3]=4 with requesters 3 and 4
    step(16'h0000, 0, 1, 3, 4);
    for (int k = 0; k < 20; k++) begin
      step(16'h0018, 0, 0, 0, 0);
      chk("wrr_seq", 32'(bus.grant_idx), (k % 5 < 4) ? 32'd3 : 32'd4);
    end

    // Single requester, then drop
    for (int k = 0; k < 4; k++) begin
      step(16'h0001, 0, 0, 0, 0);
      chk("single_req", 32'(bus.grant_idx), 32'd0);
    end
    step(16'h0000, 0, 0, 0, 0);
    chk("drop_grant_v", 32'(bus.grant_v), 32'd0);
    chk("drop_stall", 32'(bus.stall), 32'd0);

    // Back-pressure mid-burst
    step(16'h0018, 0, 0, 0, 0); chk("bp_pre0", 32'(bus.grant_idx), 32'd3);
    step(16'h0018, 0, 0, 0, 0); chk("bp_pre1", 32'(bus.grant_idx), 32'd3);
    for (int k = 0; k < 5; k++) begin
      step(16'h0018, 1, 0, 0, 0);
      chk("bp_stall", 32'(bus.stall), 32'd1);
    end
    step(16'h0018, 0, 0, 0, 0); chk("bp_post0", 32'(bus.grant_idx), 32'd3);
    step(16'h0018, 0, 0, 0, 0); chk("bp_post1", 32'(bus.grant_idx), 32'd3);
    step(16'h0018, 0, 0, 0, 0); chk("bp_post2", 32'(bus.grant_idx), 32'd4);

    // Zero weight written to the current owner mid-burst
    step(16'h0000, 0, 1, 5, 3);
    step(16'h0060, 0, 0, 0, 0); chk("mask_a", 32'(bus.grant_idx), 32'd5);
    step(16'h0060, 0, 1, 5, 0); chk("mask_b", 32'(bus.grant_idx), 32'd5);
    for (int k = 0; k < 5; k++) begin
      step(16'h0060, 0, 0, 0, 0);
      chk("mask_skip", 32'(bus.grant_idx), 32'd6);
    end
    step(16'h0060, 0, 1, 5, 1); chk("unmask_a", 32'(bus.grant_idx), 32'd6);
    step(16'h0060, 0, 0, 0, 0); chk("unmask_b", 32'(bus.grant_idx), 32'd5);

    // Reset mid-burst restores weights and search origin
    step(16'h0018, 0, 0, 0, 0); chk("rb_a", 32'(bus.grant_idx), 32'd3);
    step(16'h0018, 0, 0, 0, 0); chk("rb_b", 32'(bus.grant_idx), 32'd3);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(16'hFFFF, 0, 0, 0, 0);
      chk("post_rst_rr", 32'(bus.grant_idx), 32'(i));
    end

    // Randomized traffic, back-pressure, reweighting and occasional reset
    for (int n = 0; n < 800; n++) begin
      logic [N-1:0] rq;
      bit af, wen;
      int cw;
      rq  = N'($urandom & $urandom);
      af  = ($urandom_range(0, 3) == 0);
      wen = ($urandom_range(0, 7) == 0);
      cw  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(rq, af, wen, int'($urandom_range(0, N - 1)), cw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
